// File: rtl/nmr_pls_train_dpath.sv
// rtl/nmr_pls_train_dpath.sv - NMR pulse-train sequencer: delay, N phased pulses with gaps, post delay
module nmr_pls_train_dpath #(
  parameter int DLY_WIDTH = 32,
  parameter int PLS_WIDTH = 32,
  parameter int NUM_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [DLY_WIDTH-1:0] idly,
  input  logic [PLS_WIDTH-1:0] pls,
  input  logic [DLY_WIDTH-1:0] gap,
  input  logic [DLY_WIDTH-1:0] edly,
  input  logic [NUM_WIDTH-1:0] n_pls,
  input  logic [1:0]           ph_init,
  input  logic [1:0]           ph_step,
  output logic                 OUT,
  output logic [1:0]           PH,
  output logic [NUM_WIDTH-1:0] PLS_CNT,
  output logic                 DONE
);

  // Counter is one bit wider than the widest operand so all-ones lengths never wrap.
  localparam int CW = ((DLY_WIDTH > PLS_WIDTH) ? DLY_WIDTH : PLS_WIDTH) + 1;
  localparam logic [CW-1:0]        ONE_C = 1;
  localparam logic [NUM_WIDTH-1:0] ONE_N = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IDLY = 3'd1,
    S_PLS  = 3'd2,
    S_GAP  = 3'd3,
    S_EDLY = 3'd4,
    S_END  = 3'd5
  } state_t;

  state_t               state, nxt_state;
  logic [CW-1:0]        cnt, nxt_cnt;
  logic [PLS_WIDTH-1:0] pls_r;
  logic [DLY_WIDTH-1:0] gap_r, edly_r;
  logic [NUM_WIDTH-1:0] n_r, nxt_pcnt;
  logic [1:0]           step_r;
  // acc holds the phase of pulse number PLS_CNT (the next pulse to start).
  logic [1:0]           acc, nxt_acc, nxt_ph;
  // zero_r marks a run whose total length is zero: DONE never drops.
  logic                 zero_r, nxt_zero;
  logic                 out_d, done_d;
  logic                 start_run, zero_in;
  logic                 go_entry, go_edly;
  logic [NUM_WIDTH-1:0] ent_k, k1;
  logic [1:0]           ent_a, a1;

  assign start_run = (state == S_IDLE) && START && !ABORT;
  assign zero_in   = (idly == '0) && (edly == '0) &&
                     ((n_pls == '0) || ((pls == '0) && ((n_pls == ONE_N) || (gap == '0))));

  // State, counters, captured run parameters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      PLS_CNT <= '0;
      acc     <= 2'd0;
      PH      <= 2'd0;
      zero_r  <= 1'b0;
      OUT     <= 1'b0;
      DONE    <= 1'b1;
      pls_r   <= '0;
      gap_r   <= '0;
      edly_r  <= '0;
      n_r     <= '0;
      step_r  <= 2'd0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      PLS_CNT <= nxt_pcnt;
      acc     <= nxt_acc;
      PH      <= nxt_ph;
      zero_r  <= nxt_zero;
      OUT     <= out_d;
      DONE    <= done_d;
      if (start_run) begin
        pls_r  <= pls;
        gap_r  <= gap;
        edly_r <= edly;
        n_r    <= n_pls;
        step_r <= ph_step;
      end
    end
  end

  // Next state: count down each phase, folding zero-length phases into the same edge.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pcnt  = PLS_CNT;
    nxt_acc   = acc;
    nxt_ph    = PH;
    nxt_zero  = zero_r;
    go_entry  = 1'b0;
    go_edly   = 1'b0;
    ent_k     = PLS_CNT;
    ent_a     = acc;
    k1        = PLS_CNT + ONE_N;
    a1        = acc + step_r;
    case (state)
      S_IDLE: begin
        // The START edge itself is counted as the first IDLY period.
        if (START && !ABORT) begin
          nxt_state = S_IDLY;
          nxt_cnt   = CW'(idly);
          nxt_pcnt  = '0;
          nxt_acc   = ph_init;
          nxt_zero  = zero_in;
        end
      end
      S_IDLY, S_GAP: begin
        if (ABORT)            nxt_state = S_END;
        else if (cnt != '0)   nxt_cnt   = cnt - ONE_C;
        else                  go_entry  = 1'b1;
      end
      S_PLS: begin
        if (ABORT) begin
          nxt_state = S_END;
        end else if (cnt != '0) begin
          nxt_cnt = cnt - ONE_C;
        end else begin
          nxt_pcnt = k1;
          nxt_acc  = a1;
          if (k1 == n_r) begin
            go_edly = 1'b1;
          end else if (gap_r != '0) begin
            nxt_state = S_GAP;
            nxt_cnt   = CW'(gap_r) - ONE_C;
          end else begin
            go_entry = 1'b1;
            ent_k    = k1;
            ent_a    = a1;
          end
        end
      end
      S_EDLY: begin
        if (ABORT)            nxt_state = S_END;
        else if (cnt != '0)   nxt_cnt   = cnt - ONE_C;
        else                  nxt_state = S_END;
      end
      S_END: begin
        if (!START) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase

    // Start of pulse ent_k; a zero-width pulse completes at once.
    if (go_entry) begin
      nxt_pcnt = ent_k;
      nxt_acc  = ent_a;
      if (ent_k == n_r) begin
        go_edly = 1'b1;
      end else if (pls_r != '0) begin
        nxt_state = S_PLS;
        nxt_cnt   = CW'(pls_r) - ONE_C;
        nxt_ph    = ent_a;
      end else if (ent_k + ONE_N == n_r) begin
        nxt_pcnt = ent_k + ONE_N;
        go_edly  = 1'b1;
      end else if (gap_r != '0) begin
        nxt_state = S_GAP;
        nxt_cnt   = CW'(gap_r) - ONE_C;
        nxt_pcnt  = ent_k + ONE_N;
        nxt_acc   = ent_a + step_r;
      end else begin
        // Zero pulses and zero gaps: every remaining pulse completes now.
        nxt_pcnt = n_r;
        go_edly  = 1'b1;
      end
    end

    if (go_edly) begin
      if (edly_r != '0) begin
        nxt_state = S_EDLY;
        nxt_cnt   = CW'(edly_r) - ONE_C;
      end else begin
        nxt_state = S_END;
      end
    end
  end

  // Output decode from the upcoming state so OUT and DONE come straight from flops.
  always_comb begin
    out_d  = (nxt_state == S_PLS);
    done_d = (nxt_state == S_IDLE) || (nxt_state == S_END) ||
             ((nxt_state == S_IDLY) && nxt_zero);
  end

endmodule

// File: tb/tb_nmr_pls_train_dpath.sv
// tb/tb_nmr_pls_train_dpath.sv - randomized self-checking bench for nmr_pls_train_dpath
module tb_nmr_pls_train_dpath;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT;
  logic [31:0] idly, pls, gap, edly;
  logic [15:0] n_pls;
  logic [1:0]  ph_init, ph_step;
  logic        OUT, DONE;
  logic [1:0]  PH;
  logic [15:0] PLS_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  // run parameters seen by the reference model
  int m_idly, m_pls, m_gap, m_edly, m_n, m_phi, m_phs, m_abort;
  int ph_hold;
  int last_cnt;

  nmr_pls_train_dpath #(.DLY_WIDTH(32), .PLS_WIDTH(32), .NUM_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .idly(idly), .pls(pls), .gap(gap), .edly(edly), .n_pls(n_pls),
    .ph_init(ph_init), .ph_step(ph_step),
    .OUT(OUT), .PH(PH), .PLS_CNT(PLS_CNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: t is the offset of the clock period from the start edge E0.
  function automatic int m_total();
    return m_idly + m_n * m_pls + ((m_n > 0) ? (m_n - 1) * m_gap : 0) + m_edly;
  endfunction

  function automatic int raw_out(int t);
    for (int k = 0; k < m_n; k++)
      if (t >= 1 + m_idly + k * (m_pls + m_gap) && t <= m_idly + (k + 1) * m_pls + k * m_gap)
        return 1;
    return 0;
  endfunction

  function automatic int raw_cnt(int t);
    int c = 0;
    for (int k = 0; k < m_n; k++)
      if (m_idly + (k + 1) * m_pls + k * m_gap + 1 <= t) c++;
    return c;
  endfunction

  function automatic int raw_ph(int t);
    int p = ph_hold;
    if (m_pls > 0)
      for (int k = 0; k < m_n; k++)
        if (1 + m_idly + k * (m_pls + m_gap) <= t) p = (m_phi + k * m_phs) % 4;
    return p;
  endfunction

  function automatic int raw_done(int t);
    if (m_total() == 0) return 1;
    return (t <= m_total()) ? 0 : 1;
  endfunction

  function automatic bit aborted(int t);
    return (m_abort > 0) && (t >= m_abort);
  endfunction

  function automatic int exp_out(int t);  return aborted(t) ? 0 : raw_out(t); endfunction
  function automatic int exp_done(int t); return aborted(t) ? 1 : raw_done(t); endfunction
  function automatic int exp_cnt(int t);  return aborted(t) ? raw_cnt(m_abort - 1) : raw_cnt(t); endfunction
  function automatic int exp_ph(int t);   return aborted(t) ? raw_ph(m_abort - 1) : raw_ph(t); endfunction

  task automatic check_period(input string tag, input int t);
    check($sformatf("%s t=%0d OUT", tag, t),     64'(OUT),     64'(exp_out(t)));
    check($sformatf("%s t=%0d DONE", tag, t),    64'(DONE),    64'(exp_done(t)));
    check($sformatf("%s t=%0d PLS_CNT", tag, t), 64'(PLS_CNT), 64'(exp_cnt(t)));
    check($sformatf("%s t=%0d PH", tag, t),      64'(PH),      64'(exp_ph(t)));
  endtask

  task automatic scramble_inputs();
    idly    = $urandom;
    pls     = $urandom;
    gap     = $urandom;
    edly    = $urandom;
    n_pls   = 16'($urandom);
    ph_init = 2'($urandom);
    ph_step = 2'($urandom);
  endtask

  task automatic set_run(input int i_, input int p_, input int g_, input int e_, input int n_,
                         input int phi, input int phs, input int ab);
    m_idly = i_; m_pls = p_; m_gap = g_; m_edly = e_; m_n = n_;
    m_phi = phi; m_phs = phs; m_abort = ab;
    idly = 32'(i_); pls = 32'(p_); gap = 32'(g_); edly = 32'(e_); n_pls = 16'(n_);
    ph_init = 2'(phi); ph_step = 2'(phs);
  endtask

  // Next posedge is E0; START stays high past END, then drops to return to IDLE.
  task automatic run_body(input string tag);
    int tmax;
    @(posedge CLK);
    #1 scramble_inputs();
    tmax = ((m_abort > 0) ? m_abort : m_total() + 1) + 3;
    for (int t = 0; t <= tmax; t++) begin
      @(negedge CLK);
      check_period(tag, t);
      ABORT = (m_abort > 0) && (t + 1 == m_abort);
    end
    ABORT    = 1'b0;
    ph_hold  = exp_ph(tmax);
    last_cnt = exp_cnt(tmax);
    START    = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " idle DONE"}, 64'(DONE), 64'd1);
    check({tag, " idle OUT"},  64'(OUT),  64'd0);
  endtask

  task automatic run_one(input string tag, input int i_, input int p_, input int g_, input int e_,
                         input int n_, input int phi, input int phs, input int ab);
    set_run(i_, p_, g_, e_, n_, phi, phs, ab);
    START = 1'b1;
    ABORT = 1'b0;
    run_body(tag);
  endtask

  initial begin
    int i_, p_, g_, e_, n_, ab;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    set_run(0, 0, 0, 0, 0, 0, 0, 0);
    ph_hold = 0; last_cnt = 0;
    #13;
    check("reset OUT",     64'(OUT),     64'd0);
    check("reset DONE",    64'(DONE),    64'd1);
    check("reset PH",      64'(PH),      64'd0);
    check("reset PLS_CNT", 64'(PLS_CNT), 64'd0);
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("post-reset idle DONE", 64'(DONE), 64'd1);

    run_one("basic",     3, 2, 4, 5, 3, 0, 1, 0);
    run_one("allzero",   0, 0, 0, 0, 0, 2, 1, 0);
    run_one("zeropls",   1, 0, 2, 1, 2, 1, 1, 0);
    run_one("phase",     1, 2, 1, 1, 4, 3, 2, 0);
    run_one("abort2nd",  3, 2, 4, 5, 3, 0, 1, 11);
    run_one("b2b",       0, 3, 0, 0, 3, 1, 3, 0);
    run_one("onezero",   0, 0, 5, 0, 1, 0, 0, 0);

    // ABORT together with START in IDLE must not start a run.
    set_run(2, 1, 1, 1, 2, 1, 1, 0);
    START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort+start DONE",    64'(DONE),    64'd1);
    check("abort+start PLS_CNT", 64'(PLS_CNT), 64'(last_cnt));
    ABORT = 1'b0;
    run_body("after-abort-start");

    // Asynchronous reset in the middle of a gap, START held through it.
    set_run(3, 2, 4, 5, 3, 0, 1, 0);
    START = 1'b1;
    @(posedge CLK);
    #1 scramble_inputs();
    for (int t = 0; t <= 7; t++) begin
      @(negedge CLK);
      check_period("pre-rst", t);
    end
    #2 RST = 1'b1;
    #1;
    check("async rst OUT",     64'(OUT),     64'd0);
    check("async rst DONE",    64'(DONE),    64'd1);
    check("async rst PH",      64'(PH),      64'd0);
    check("async rst PLS_CNT", 64'(PLS_CNT), 64'd0);
    set_run(2, 1, 1, 1, 2, 2, 3, 0);
    ph_hold = 0;
    @(negedge CLK); RST = 1'b0;
    run_body("after-rst");

    for (int r = 0; r < 40; r++) begin
      i_ = $urandom_range(0, 6);
      p_ = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      g_ = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      e_ = $urandom_range(0, 6);
      n_ = $urandom_range(0, 5);
      m_idly = i_; m_pls = p_; m_gap = g_; m_edly = e_; m_n = n_;
      ab = 0;
      if (m_total() > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, m_total());
      run_one($sformatf("rnd%0d", r), i_, p_, g_, e_, n_,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nmr_pls_train_dpath.md
NMR_PLS_TRAIN_DPATH -- requirements
Module: nmr_pls_train_dpath

Interface
REQ-001 SHALL have parameter DLY_WIDTH, default 32, width of idly/gap/edly.
REQ-002 SHALL have parameter PLS_WIDTH, default 32, width of pls.
REQ-003 SHALL have parameter NUM_WIDTH, default 16, width of n_pls and PLS_CNT.
REQ-004 SHALL have ports as follows; reset RST, asynchronous, active-high; clock CLK:
 CLK  in  1  clock
 RST  in  1  asynchronous active-high reset
 START  in  1  run request, level
 ABORT  in  1  synchronous run termination
 idly  in  DLY_WIDTH  pre-train delay, cycles
 pls  in  PLS_WIDTH  pulse width, cycles
 gap  in  DLY_WIDTH  inter-pulse gap, cycles
 edly  in  DLY_WIDTH  post-train delay, cycles
 n_pls  in  NUM_WIDTH  pulse count
 ph_init  in  2  phase of pulse 0
 ph_step  in  2  phase increment per pulse
 OUT  out  1  pulse gate
 PH  out  2  phase select of current/last pulse
 PLS_CNT  out  NUM_WIDTH  pulses completed this run
 DONE  out  1  idle/complete flag

Function
REQ-005 SHALL implement states IDLE, IDLY, PLS, GAP, EDLY, END; all outputs registered.
REQ-006 In IDLE, DONE SHALL be 1 and OUT 0; START sampled high at edge E0 SHALL start a run.
REQ-007 At E0, idly, pls, gap, edly, n_pls, ph_init, ph_step SHALL be captured; input changes during a run SHALL be ignored.
REQ-008 At E0, PLS_CNT SHALL clear to 0 and DONE SHALL fall.
REQ-009 Sequence SHALL be: IDLY (idly cycles), then for k=0..n_pls-1: PLS (pls cycles) followed by GAP (gap cycles) except after last pulse, then EDLY (edly cycles), then END.
REQ-010 Any phase of length 0 SHALL be skipped with zero cycles consumed; n_pls=0 SHALL go IDLY->EDLY.
REQ-011 Pulse k SHALL drive OUT=1 in the clock periods beginning at edges E0+1+idly+k*(pls+gap) through E0+idly+(k+1)*pls+k*gap inclusive; OUT=0 otherwise.
REQ-012 PH SHALL update to (ph_init + k*ph_step) mod 4 at the edge OUT rises for pulse k, and hold until the next pulse or run start.
REQ-013 PLS_CNT SHALL increment by 1 at the end of each PLS phase (including zero-length PLS), saturating at n_pls.
REQ-014 With T = idly + n_pls*pls + max(n_pls-1,0)*gap + edly, DONE SHALL be 0 for periods beginning at edges E0+1..E0+T and 1 from edge E0+T+1 (END); T=0 leaves DONE continuously 1.
REQ-015 Cycle counters SHALL be one bit wider than their operand so maximum values (all ones) run without wrap.
REQ-016 In END, DONE=1, OUT=0; state SHALL return to IDLE only at an edge where START is 0; START held high SHALL NOT retrigger.
REQ-017 ABORT high at an edge in IDLY/PLS/GAP/EDLY SHALL force END at that edge with OUT=0, DONE=1, PLS_CNT frozen.
REQ-018 ABORT SHALL be ignored in IDLE and END; ABORT and START both high in IDLE SHALL not start a run.

Reset
REQ-019 RST high SHALL immediately force IDLE, OUT=0, DONE=1, PH=0, PLS_CNT=0, counters cleared, regardless of state.
REQ-020 After RST release, a run SHALL start only on START sampled high at a subsequent edge.

Verification
REQ-021 idly=3, pls=2, gap=4, edly=5, n_pls=3, ph_init=0, ph_step=1 -> OUT high at E0+4..5, +10..11, +16..17; PH 0,1,2; PLS_CNT=3; DONE rises E0+23.
REQ-022 all timing values 0, n_pls=0 -> OUT never high, DONE stays 1, PLS_CNT=0, START low returns to IDLE.
REQ-023 n_pls=2, pls=0, gap=2, idly=1, edly=1 -> OUT never high, PLS_CNT=2, DONE rises E0+5.
REQ-024 ABORT asserted during second pulse of REQ-021 run -> OUT 0 next edge, DONE 1, PLS_CNT=1, no further pulses.
REQ-025 RST asserted mid-GAP -> all outputs at reset values asynchronously; START held high after release -> new run from IDLY with fresh capture.
REQ-026 ph_init=3, ph_step=2, n_pls=4, START held high past END -> PH 3,1,3,1; no retrigger until START low then high.
